// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared encodings, FSM state type and address-field widths for the data cache
package dcache_pkg;

  localparam logic [2:0] ADDR_B  = 3'b000;
  localparam logic [2:0] ADDR_H  = 3'b001;
  localparam logic [2:0] ADDR_W  = 3'b010;
  localparam logic [2:0] ADDR_BU = 3'b100;
  localparam logic [2:0] ADDR_HU = 3'b101;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_WRITE,
    S_WDONE
  } dcache_state_t;

  function automatic int word_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_bits(input int sets, input int line_words);
    return 32 - 2 - word_bits(line_words) - index_bits(sets);
  endfunction

endpackage

// File: rtl/dcache_load_align.sv
// rtl/dcache_load_align.sv - selects the addressed byte/half of a cached word and sign- or zero-extends it
module dcache_load_align
  import dcache_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [2:0]  i_ctrl,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_offset)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

    case (i_ctrl)
      ADDR_B:  o_data = {{24{w_byte[7]}}, w_byte};
      ADDR_H:  o_data = {{16{w_half[15]}}, w_half};
      ADDR_BU: o_data = {24'h0, w_byte};
      ADDR_HU: o_data = {16'h0, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/dcache_mem_stage.sv
// rtl/dcache_mem_stage.sv - direct-mapped write-through no-allocate D-cache memory stage; DCACHE_STATS_EN adds hit/miss counters
module dcache_mem_stage
  import dcache_pkg::*;
#(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ResultSrcM,
  input  logic        MemWriteM,
  input  logic [2:0]  AddressingControlM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int WB = word_bits(LINE_WORDS);
  localparam int IB = index_bits(SETS);
  localparam int TB = tag_bits(SETS, LINE_WORDS);

  dcache_state_t r_state, w_state_next;
  logic [WB-1:0] r_cnt;
  logic [SETS-1:0] r_valid;
  logic [TB-1:0] r_tag [SETS];
  logic [31:0] r_data [SETS*LINE_WORDS];

  logic [1:0]    w_offset;
  logic [WB-1:0] w_word;
  logic [IB-1:0] w_index;
  logic [TB-1:0] w_tag;
  logic          w_load, w_store, w_hit, w_last;
  logic [31:0]   w_cached, w_aligned, w_merged, w_wdata, w_addr;
  logic [3:0]    w_be;
  logic          w_stall, w_req, w_we;

  assign w_offset = ALUResultM[1:0];
  assign w_word   = ALUResultM[2 +: WB];
  assign w_index  = ALUResultM[2+WB +: IB];
  assign w_tag    = ALUResultM[31 -: TB];
  assign w_store  = MemWriteM;
  assign w_load   = (ResultSrcM == RESULT_SRC_LOAD) && !MemWriteM;
  assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_last   = (r_cnt == WB'(LINE_WORDS - 1));
  assign w_cached = r_data[{w_index, w_word}];

  dcache_load_align u_align (
    .i_word   (w_cached),
    .i_offset (w_offset),
    .i_ctrl   (AddressingControlM),
    .o_data   (w_aligned)
  );

  assign ReadDataM = w_load ? w_aligned : 32'd0;

  // Store lane placement; ignored low address bits are masked per size.
  always_comb begin
    case (AddressingControlM[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_offset;
        w_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {w_offset[1], 1'b0};
        w_wdata = {2{WriteDataM[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
      end
    endcase
    w_merged = w_cached;
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) w_merged[8*b +: 8] = w_wdata[8*b +: 8];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    w_req        = 1'b0;
    w_we         = 1'b0;
    w_addr       = {ALUResultM[31:2], 2'b00};
    case (r_state)
      S_IDLE: begin
        if (w_store) begin
          w_stall      = 1'b1;
          w_state_next = S_WRITE;
        end else if (w_load && !w_hit) begin
          w_stall      = 1'b1;
          w_state_next = S_REFILL;
        end
      end
      S_REFILL: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
        w_addr  = {w_tag, w_index, r_cnt, 2'b00};
        if (mem_ready && w_last) w_state_next = S_IDLE;
      end
      S_WRITE: begin
        w_stall = 1'b1;
        w_req   = 1'b1;
        w_we    = 1'b1;
        if (mem_ready) w_state_next = S_WDONE;
      end
      S_WDONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Reset also quiets the bus in the same cycle so memory sees the drop immediately.
  assign StallM    = w_stall && !rst;
  assign mem_req   = w_req && !rst;
  assign mem_we    = w_we && !rst;
  assign mem_addr  = w_addr;
  assign mem_wdata = w_wdata;
  assign mem_be    = w_be;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_valid <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
        if (!w_store && w_load && !w_hit) r_valid[w_index] <= 1'b0;
      end else if (r_state == S_REFILL && mem_ready) begin
        r_cnt <= r_cnt + WB'(1);
        if (w_last) r_valid[w_index] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == S_REFILL && mem_ready) begin
        r_data[{w_index, r_cnt}] <= mem_rdata;
        if (w_last) r_tag[w_index] <= w_tag;
      end else if (r_state == S_WRITE && mem_ready && w_hit) begin
        r_data[{w_index, w_word}] <= w_merged;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] r_hit_count, r_miss_count;
  logic        r_after_refill;

  // The IDLE cycle right after a refill is the same load finally hitting; it was already counted as a miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_count    <= 32'd0;
      r_miss_count   <= 32'd0;
      r_after_refill <= 1'b0;
    end else begin
      r_after_refill <= (r_state == S_REFILL) && mem_ready && w_last;
      if (r_state == S_IDLE && (w_load || w_store)) begin
        if (!w_hit) r_miss_count <= r_miss_count + 32'd1;
        else if (!r_after_refill) r_hit_count <= r_hit_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_mem_stage.sv
// tb/tb_dcache_mem_stage.sv - self-checking bench for dcache_mem_stage (counter checks follow DCACHE_STATS_EN)
module tb_dcache_mem_stage;

  localparam int SETS       = 64;
  localparam int LINE_WORDS = 4;
  localparam int LINE_BYTES = LINE_WORDS * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [2:0]  AddressingControlM;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM;
  logic        StallM, mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, hit_count, miss_count;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  dcache_mem_stage #(.SETS(SETS), .LINE_WORDS(LINE_WORDS)) dut (
    .clk(clk), .rst(rst), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .AddressingControlM(AddressingControlM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .hit_count(hit_count), .miss_count(miss_count)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // env_mem is the memory the DUT talks to; ref_mem/ref_line are the reference model.
  logic [31:0] env_mem [int unsigned];
  logic [31:0] ref_mem [int unsigned];
  int unsigned ref_line [int unsigned];
  int unsigned ref_hits = 0, ref_misses = 0;

  int          lat = 0;
  int          wait_left = 0;
  bit          force_ready = 1'b0;
  bit          seen_write;
  logic [3:0]  seen_be;
  logic [31:0] seen_wdata;
  logic        s_stall, s_req, s_we;
  logic [31:0] s_rdata;

  typedef struct {
    bit          st;
    logic [31:0] a;
    logic [2:0]  f3;
    logic [31:0] d;
    logic [31:0] exp_data;
    int          exp_stall;
    logic [3:0]  exp_be;
  } vec_t;
  vec_t vt[$];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC3A5_0F1E;
  endfunction

  function automatic logic [31:0] env_rd(input logic [31:0] wa);
    return env_mem.exists(wa) ? env_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    for (int b = 0; b < 4; b++) if (be[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    w = ref_rd({a[31:2], 2'b00});
    b = 8'(w >> (8 * a[1:0]));
    h = 16'(w >> (16 * a[1]));
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'h0, b};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    env_mem[a] = d;
    ref_mem[a] = d;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // One clock: answer the memory bus, sample outputs, then cross the active edge.
  task automatic cycle();
    logic [31:0] w;
    #1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    if (force_ready) begin
      mem_ready = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
    end else if (mem_req) begin
      if (wait_left > 0) wait_left--;
      else begin
        mem_ready = 1'b1;
        wait_left = lat;
        if (mem_we) begin
          w = env_rd(mem_addr);
          for (int b = 0; b < 4; b++) if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          env_mem[mem_addr] = w;
          seen_write = 1'b1;
          seen_be    = mem_be;
          seen_wdata = mem_wdata;
        end else begin
          mem_rdata = env_rd(mem_addr);
        end
      end
    end
    #1;
    s_stall = StallM;
    s_req   = mem_req;
    s_we    = mem_we;
    s_rdata = ReadDataM;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_op(input bit st, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] d,
                          output logic [31:0] exp_data, output int exp_stall,
                          output logic [3:0] exp_be, output logic [31:0] exp_lanes);
    int unsigned line, set;
    int          size, first;
    bit          hit;
    logic [31:0] wa, w;
    line = a / LINE_BYTES;
    set  = line % SETS;
    hit  = ref_line.exists(set) && (ref_line[set] == line);
    if (hit) ref_hits++; else ref_misses++;
    exp_data = 32'h0; exp_be = 4'h0; exp_lanes = 32'h0;
    if (st) begin
      size  = 1 << f3[1:0];
      first = int'(a[1:0]) & ~(size - 1) & 3;
      wa    = {a[31:2], 2'b00};
      w     = ref_rd(wa);
      for (int k = 0; k < size; k++) begin
        exp_be[first+k] = 1'b1;
        w[8*(first+k) +: 8]         = d[8*k +: 8];
        exp_lanes[8*(first+k) +: 8] = d[8*k +: 8];
      end
      ref_mem[wa] = w;
      exp_stall = 2 + lat;
    end else begin
      if (!hit) begin
        ref_line[set] = line;
        exp_stall = 1 + LINE_WORDS * (lat + 1);
      end else begin
        exp_stall = 0;
      end
      exp_data = ref_load(a, f3);
    end
  endtask

  task automatic run_op(input string nm, input bit st, input logic [31:0] a, input logic [2:0] f3,
                        input logic [31:0] d, input logic [31:0] exp_data, input int exp_stall,
                        input logic [3:0] exp_be, input logic [31:0] exp_lanes);
    int n;
    int stalls;
    stalls = 0;
    seen_write = 1'b0;
    wait_left = lat;
    ResultSrcM = st ? 2'b00 : 2'b01;
    MemWriteM = st;
    AddressingControlM = f3;
    ALUResultM = a;
    WriteDataM = d;
    for (n = 0; n < 100; n++) begin
      cycle();
      if (!s_stall) break;
      stalls++;
    end
    if (n == 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s release: still stalled after %0d cycles, required release", nm, n);
    end
    check({nm, " data"}, s_rdata, exp_data);
    check({nm, " stall"}, 32'(stalls), 32'(exp_stall));
    check({nm, " wrote"}, 32'(seen_write), 32'(st));
    if (st) begin
      check({nm, " be"}, {28'h0, seen_be}, {28'h0, exp_be});
      check({nm, " wdata"}, seen_wdata & be_mask(exp_be), exp_lanes);
    end
    ResultSrcM = 2'b00;
    MemWriteM = 1'b0;
  endtask

  task automatic check_counters(input string nm);
`ifdef DCACHE_STATS_EN
    check({nm, " hit_count"}, hit_count, ref_hits);
    check({nm, " miss_count"}, miss_count, ref_misses);
`else
    check({nm, " hit_count"}, hit_count, 32'h0);
    check({nm, " miss_count"}, miss_count, 32'h0);
`endif
  endtask

  initial begin
    logic [31:0] md, ml;
    int          ms;
    logic [3:0]  mb;

    rst = 1'b1; ResultSrcM = 2'b00; MemWriteM = 1'b0; AddressingControlM = 3'b010;
    ALUResultM = 32'h0; WriteDataM = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    preload(32'h100, 32'h11); preload(32'h104, 32'h22);
    preload(32'h108, 32'h33); preload(32'h10C, 32'h44);
    preload(32'h504, 32'hCAFE_0504);

    //            st    addr          f3      wdata          exp_data       stall be
    vt.push_back('{1'b0, 32'h0000_0104, 3'b010, 32'h0,         32'h0000_0022, 5, 4'h0});
    vt.push_back('{1'b0, 32'h0000_0108, 3'b010, 32'h0,         32'h0000_0033, 0, 4'h0});
    vt.push_back('{1'b1, 32'h0000_010C, 3'b010, 32'h80F0_7F01, 32'h0,         2, 4'hF});
    vt.push_back('{1'b0, 32'h0000_010F, 3'b000, 32'h0,         32'hFFFF_FF80, 0, 4'h0});
    vt.push_back('{1'b0, 32'h0000_010F, 3'b100, 32'h0,         32'h0000_0080, 0, 4'h0});
    vt.push_back('{1'b0, 32'h0000_010E, 3'b001, 32'h0,         32'hFFFF_80F0, 0, 4'h0});
    vt.push_back('{1'b0, 32'h0000_010C, 3'b101, 32'h0,         32'h0000_7F01, 0, 4'h0});
    vt.push_back('{1'b0, 32'h0000_010D, 3'b101, 32'h0,         32'h0000_7F01, 0, 4'h0});
    vt.push_back('{1'b1, 32'h0000_0105, 3'b000, 32'hFFFF_FFAB, 32'h0,         2, 4'h2});
    vt.push_back('{1'b0, 32'h0000_0104, 3'b010, 32'h0,         32'h0000_AB22, 0, 4'h0});
    vt.push_back('{1'b0, 32'h0000_0106, 3'b010, 32'h0,         32'h0000_AB22, 0, 4'h0});
    vt.push_back('{1'b1, 32'h0000_2000, 3'b010, 32'h1234_5678, 32'h0,         2, 4'hF});
    vt.push_back('{1'b0, 32'h0000_2000, 3'b010, 32'h0,         32'h1234_5678, 5, 4'h0});
    vt.push_back('{1'b0, 32'h0000_0504, 3'b010, 32'h0,         32'hCAFE_0504, 5, 4'h0});
    vt.push_back('{1'b0, 32'h0000_0104, 3'b010, 32'h0,         32'h0000_AB22, 5, 4'h0});
    vt.push_back('{1'b1, 32'h0000_0107, 3'b001, 32'h0000_1234, 32'h0,         2, 4'hC});
    vt.push_back('{1'b0, 32'h0000_0106, 3'b101, 32'h0,         32'h0000_1234, 0, 4'h0});
    vt.push_back('{1'b0, 32'h0000_0104, 3'b010, 32'h0,         32'h1234_AB22, 0, 4'h0});

    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    check("reset StallM", {31'h0, s_stall}, 32'h0);
    check("reset mem_req", {31'h0, s_req}, 32'h0);
    check("reset mem_we", {31'h0, s_we}, 32'h0);
    check("reset ReadDataM", s_rdata, 32'h0);
    check_counters("reset");

    lat = 0;
    foreach (vt[i]) begin
      model_op(vt[i].st, vt[i].a, vt[i].f3, vt[i].d, md, ms, mb, ml);
      run_op($sformatf("vec%0d", i), vt[i].st, vt[i].a, vt[i].f3, vt[i].d,
             vt[i].exp_data, vt[i].exp_stall, vt[i].exp_be, ml);
    end
    check_counters("table");

    // Reset lands while the second refill word is being returned; memory keeps pulsing ready.
    ResultSrcM = 2'b01; MemWriteM = 1'b0; AddressingControlM = 3'b010; ALUResultM = 32'h3000;
    wait_left = 0;
    cycle();
    cycle();
    rst = 1'b1; force_ready = 1'b1; ResultSrcM = 2'b00;
    cycle();
    rst = 1'b0;
    cycle();
    check("post-rst mem_req", {31'h0, s_req}, 32'h0);
    check("post-rst StallM", {31'h0, s_stall}, 32'h0);
    force_ready = 1'b0;
    ref_line.delete();
    ref_hits = 0;
    ref_misses = 0;
    check_counters("post-rst");
    model_op(1'b0, 32'h104, 3'b010, 32'h0, md, ms, mb, ml);
    run_op("post-rst reload", 1'b0, 32'h104, 3'b010, 32'h0, md, 5, mb, ml);

    for (int i = 0; i < 300; i++) begin
      bit          st;
      logic [2:0]  f3;
      logic [31:0] a, d;
      st = ($urandom_range(0, 2) == 0);
      if (st) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4) |
          32'($urandom_range(0, 15));
      d = $urandom;
      lat = $urandom_range(0, 2);
      model_op(st, a, f3, d, md, ms, mb, ml);
      run_op($sformatf("rnd%0d", i), st, a, f3, d, md, ms, mb, ml);
      if ($urandom_range(0, 7) == 0) begin
        cycle();
        check($sformatf("rnd%0d idle req", i), {31'h0, s_req}, 32'h0);
        check($sformatf("rnd%0d idle stall", i), {31'h0, s_stall}, 32'h0);
      end
    end
    check_counters("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
